// File: rtl/booth_mul16_host.sv
// rtl/booth_mul16_host.sv - clocked four-phase host for the Balsa 16-bit Booth multiplier
//
// Feeds operand pairs from a FIFO to the multiplier's x/y pull channels and
// captures its z push channel into a valid/ready result register.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   op_valid/op_ready/op_x/op_y     operand pair input (push when both high)
//   res_valid/res_ready/res_z/x/y   result output with echoed operands
//   activate_0r/activate_0a         activation handshake (ack is debug only)
//   x_0r/x_0a/x_0d                  multiplicand pull channel
//   y_0r/y_0a/y_0d                  multiplier pull channel
//   z_0r/z_0a/z_0d                  product push channel
//   count                           completed results, mod 256
module booth_mul16_host #(
    parameter int SYNC_STAGES = 2,
    parameter int OP_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] op_x,
    input  logic [15:0] op_y,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_z,
    output logic [15:0] res_x,
    output logic [15:0] res_y,
    output logic        activate_0r,
    input  logic        activate_0a,
    input  logic        x_0r,
    output logic        x_0a,
    output logic [15:0] x_0d,
    input  logic        y_0r,
    output logic        y_0a,
    output logic [15:0] y_0d,
    input  logic        z_0r,
    output logic        z_0a,
    input  logic [15:0] z_0d,
    output logic [7:0]  count
);

    localparam int AW = $clog2(OP_DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(OP_DEPTH);

    typedef enum logic [1:0] {PULL_IDLE, PULL_DRIVE, PULL_ACK, PULL_RTZ} pull_state_t;
    typedef enum logic [1:0] {PUSH_IDLE, PUSH_CAPT, PUSH_ACK} push_state_t;

    // Request synchronisers; the FSMs only ever look at the last stage.
    logic [SYNC_STAGES-1:0] x_req_sync, y_req_sync, z_req_sync, act_ack_sync;
    logic x_req, y_req, z_req;
    logic act_ack_unused;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_req_sync   <= '0;
            y_req_sync   <= '0;
            z_req_sync   <= '0;
            act_ack_sync <= '0;
            activate_0r  <= 1'b0;
        end else begin
            x_req_sync   <= {x_req_sync[SYNC_STAGES-2:0], x_0r};
            y_req_sync   <= {y_req_sync[SYNC_STAGES-2:0], y_0r};
            z_req_sync   <= {z_req_sync[SYNC_STAGES-2:0], z_0r};
            act_ack_sync <= {act_ack_sync[SYNC_STAGES-2:0], activate_0a};
            activate_0r  <= 1'b1;
        end
    end

    assign x_req = x_req_sync[SYNC_STAGES-1];
    assign y_req = y_req_sync[SYNC_STAGES-1];
    assign z_req = z_req_sync[SYNC_STAGES-1];
    // Synchronised activation acknowledge is kept for probing only.
    assign act_ack_unused = act_ack_sync[SYNC_STAGES-1];

    // Current pair and pull-channel state.
    pull_state_t x_state, y_state;
    logic        pair_valid, x_served, y_served, pair_done;
    logic [15:0] pair_x, pair_y, echo_x, echo_y;

    // The pair stays at the FIFO head while in service, so the FIFO capacity
    // includes it; it is popped once both channels are past their up-phase.
    assign pair_done = pair_valid && x_served && y_served &&
                       (x_state != PULL_DRIVE) && (y_state != PULL_DRIVE);

    // Operand FIFO.
    logic [15:0] fifo_x [OP_DEPTH];
    logic [15:0] fifo_y [OP_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt, fifo_cnt_next;
    logic          push, pop, fifo_empty;

    assign push       = op_valid && op_ready;
    assign pop        = pair_done;
    assign fifo_empty = (fifo_cnt == '0);

    always_comb begin
        fifo_cnt_next = fifo_cnt;
        if (push && !pop) begin
            fifo_cnt_next = fifo_cnt + CNT_ONE;
        end else if (!push && pop) begin
            fifo_cnt_next = fifo_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_x[wr_ptr] <= op_x;
            fifo_y[wr_ptr] <= op_y;
        end
    end

    // op_ready is registered so it reads 0 in reset and a same-cycle pop
    // only shows up on the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            op_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_cnt <= fifo_cnt_next;
            op_ready <= (fifo_cnt_next != FULL_CNT);
        end
    end

    // Pair register plus the x and y pull FSMs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair_valid <= 1'b0;
            pair_x     <= '0;
            pair_y     <= '0;
            echo_x     <= '0;
            echo_y     <= '0;
            x_served   <= 1'b0;
            y_served   <= 1'b0;
            x_state    <= PULL_IDLE;
            y_state    <= PULL_IDLE;
            x_0a       <= 1'b0;
            y_0a       <= 1'b0;
            x_0d       <= '0;
            y_0d       <= '0;
        end else begin
            if (pair_done) begin
                // Keep a copy for the result echo; the next pair may load
                // before the multiplier pushes this pair's product.
                pair_valid <= 1'b0;
                x_served   <= 1'b0;
                y_served   <= 1'b0;
                echo_x     <= pair_x;
                echo_y     <= pair_y;
            end else if (!pair_valid && !fifo_empty) begin
                pair_valid <= 1'b1;
                pair_x     <= fifo_x[rd_ptr];
                pair_y     <= fifo_y[rd_ptr];
            end

            case (x_state)
                PULL_IDLE: begin
                    if (x_req && pair_valid && !x_served) begin
                        x_0d     <= pair_x;
                        x_served <= 1'b1;
                        x_state  <= PULL_DRIVE;
                    end
                end
                PULL_DRIVE: begin
                    x_0a    <= 1'b1;
                    x_state <= PULL_ACK;
                end
                PULL_ACK: begin
                    if (!x_req) begin
                        x_0a    <= 1'b0;
                        x_state <= PULL_RTZ;
                    end
                end
                default: x_state <= PULL_IDLE;
            endcase

            case (y_state)
                PULL_IDLE: begin
                    if (y_req && pair_valid && !y_served) begin
                        y_0d     <= pair_y;
                        y_served <= 1'b1;
                        y_state  <= PULL_DRIVE;
                    end
                end
                PULL_DRIVE: begin
                    y_0a    <= 1'b1;
                    y_state <= PULL_ACK;
                end
                PULL_ACK: begin
                    if (!y_req) begin
                        y_0a    <= 1'b0;
                        y_state <= PULL_RTZ;
                    end
                end
                default: y_state <= PULL_IDLE;
            endcase
        end
    end

    // z push FSM and result register.
    push_state_t z_state;
    logic        slot_free;

    assign slot_free = !res_valid || res_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_state   <= PUSH_IDLE;
            z_0a      <= 1'b0;
            res_valid <= 1'b0;
            res_z     <= '0;
            res_x     <= '0;
            res_y     <= '0;
            count     <= '0;
        end else begin
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            case (z_state)
                PUSH_IDLE: begin
                    // Withholding the acknowledge is the back-pressure path.
                    if (z_req && slot_free) begin
                        z_state <= PUSH_CAPT;
                    end
                end
                PUSH_CAPT: begin
                    res_z     <= z_0d;
                    res_x     <= echo_x;
                    res_y     <= echo_y;
                    res_valid <= 1'b1;
                    count     <= count + 8'd1;
                    z_0a      <= 1'b1;
                    z_state   <= PUSH_ACK;
                end
                PUSH_ACK: begin
                    if (!z_req) begin
                        z_0a    <= 1'b0;
                        z_state <= PUSH_IDLE;
                    end
                end
                default: z_state <= PUSH_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul16_host.sv
// tb/tb_booth_mul16_host.sv - directed self-checking bench for booth_mul16_host
module tb_booth_mul16_host;

    localparam int S = 2;
    localparam int D = 4;
    localparam int LIMIT = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_x = '0;
    logic [15:0] op_y = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_z, res_x, res_y;
    logic        activate_0r;
    logic        activate_0a = 1'b0;
    logic        x_0r = 1'b0;
    logic        x_0a;
    logic [15:0] x_0d;
    logic        y_0r = 1'b0;
    logic        y_0a;
    logic [15:0] y_0d;
    logic        z_0r = 1'b0;
    logic        z_0a;
    logic [15:0] z_0d = '0;
    logic [7:0]  count;

    int n_cmp = 0;
    int n_fail = 0;

    booth_mul16_host #(.SYNC_STAGES(S), .OP_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_x(op_x), .op_y(op_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_z(res_z), .res_x(res_x), .res_y(res_y),
        .activate_0r(activate_0r), .activate_0a(activate_0a),
        .x_0r(x_0r), .x_0a(x_0a), .x_0d(x_0d),
        .y_0r(y_0r), .y_0a(y_0a), .y_0d(y_0d),
        .z_0r(z_0r), .z_0a(z_0a), .z_0d(z_0d),
        .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ack(input int ch, input logic lvl, output bit to);
        logic a;
        to = 1'b1;
        for (int i = 0; i < LIMIT; i++) begin
            a = (ch == 0) ? x_0a : (ch == 1) ? y_0a : z_0a;
            if (a === lvl) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic push_op(input logic [15:0] px, input logic [15:0] py, input int max_cyc, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        op_x = px;
        op_y = py;
        op_valid = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            if (op_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic pull_xy(output logic [15:0] gx, output logic [15:0] gy, output bit to);
        bit t;
        to = 1'b0;
        @(negedge clk);
        x_0r = 1'b1; wait_ack(0, 1'b1, t); to |= t; gx = x_0d;
        x_0r = 1'b0; wait_ack(0, 1'b0, t); to |= t;
        y_0r = 1'b1; wait_ack(1, 1'b1, t); to |= t; gy = y_0d;
        y_0r = 1'b0; wait_ack(1, 1'b0, t); to |= t;
    endtask

    // Behavioural multiplier: one full x, y, z cycle; snapshots the result
    // register on the sample where z_0a is first seen high.
    task automatic mul_op(output logic [15:0] rz, output logic [15:0] rx, output logic [15:0] ry,
                          output logic rv, output logic [7:0] rc, output bit to);
        logic [15:0] gx, gy;
        logic [31:0] p;
        bit t;
        pull_xy(gx, gy, to);
        p = gx * gy;
        z_0d = p[15:0];
        z_0r = 1'b1; wait_ack(2, 1'b1, t); to |= t;
        rv = res_valid; rz = res_z; rx = res_x; ry = res_y; rc = count;
        z_0r = 1'b0; wait_ack(2, 1'b0, t); to |= t;
    endtask

    task automatic test_reset;
        #12;
        n_cmp++; if ({op_ready, activate_0r, x_0a, y_0a, z_0a, res_valid} !== 6'b0) begin n_fail++; $display("FAIL reset_ctl got %b want 000000", {op_ready, activate_0r, x_0a, y_0a, z_0a, res_valid}); end
        n_cmp++; if (count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if ({res_z, res_x, res_y, x_0d, y_0d} !== 80'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", {res_z, res_x, res_y, x_0d, y_0d}); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (activate_0r !== 1'b1) begin n_fail++; $display("FAIL reset_activate got %b want 1", activate_0r); end
        n_cmp++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_op_ready got %b want 1", op_ready); end
    endtask

    task automatic test_basic;
        logic [15:0] rz, rx, ry;
        logic rv;
        logic [7:0] rc;
        bit ok, to;
        res_ready = 1'b1;
        push_op(16'd10000, 16'd3, LIMIT, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_push1 got rejected want accepted"); end
        push_op(16'd3, 16'd10000, LIMIT, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_push2 got rejected want accepted"); end
        mul_op(rz, rx, ry, rv, rc, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL basic1_timeout got timeout want handshake"); end
        n_cmp++; if (rv !== 1'b1) begin n_fail++; $display("FAIL basic1_valid_with_ack got %b want 1", rv); end
        n_cmp++; if ({rz, rx, ry} !== {16'd30000, 16'd10000, 16'd3}) begin n_fail++; $display("FAIL basic1_result got z=%0d x=%0d y=%0d want 30000 10000 3", rz, rx, ry); end
        n_cmp++; if (rc !== 8'd1) begin n_fail++; $display("FAIL basic1_count got %0d want 1", rc); end
        mul_op(rz, rx, ry, rv, rc, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL basic2_timeout got timeout want handshake"); end
        n_cmp++; if ({rv, rz, rx, ry} !== {1'b1, 16'd30000, 16'd3, 16'd10000}) begin n_fail++; $display("FAIL basic2_result got v=%b z=%0d x=%0d y=%0d want 1 30000 3 10000", rv, rz, rx, ry); end
        n_cmp++; if (rc !== 8'd2) begin n_fail++; $display("FAIL basic2_count got %0d want 2", rc); end
    endtask

    task automatic test_wrap_product;
        logic [15:0] rz, rx, ry;
        logic rv;
        logic [7:0] rc;
        bit ok, to;
        push_op(16'hFFFF, 16'hFFFF, LIMIT, ok);
        mul_op(rz, rx, ry, rv, rc, to);
        n_cmp++; if (!ok || to) begin n_fail++; $display("FAIL ffff_handshake got ok=%b to=%b want 1 0", ok, to); end
        n_cmp++; if ({rz, rx, ry} !== {16'h0001, 16'hFFFF, 16'hFFFF}) begin n_fail++; $display("FAIL ffff_result got z=%h x=%h y=%h want 0001 ffff ffff", rz, rx, ry); end
        n_cmp++; if (rc !== 8'd3) begin n_fail++; $display("FAIL ffff_count got %0d want 3", rc); end
    endtask

    task automatic test_stall;
        logic [15:0] rz, rx, ry;
        logic rv;
        logic [7:0] rc;
        bit ok, to, seen;
        @(negedge clk);
        x_0r = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (x_0a !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_fail++; $display("FAIL stall_x_ack got 1 want 0 while FIFO empty"); end
        push_op(16'd5, 16'd7, LIMIT, ok);
        for (int n = 0; n <= S + 1; n++) begin
            if (n > 0) @(negedge clk);
            n_cmp++; if (x_0a !== (n == S + 1)) begin n_fail++; $display("FAIL stall_ack_latency edge %0d got %b want %b", n, x_0a, (n == S + 1)); end
        end
        n_cmp++; if (x_0d !== 16'd5) begin n_fail++; $display("FAIL stall_x_data got %0d want 5", x_0d); end
        mul_op(rz, rx, ry, rv, rc, to);
        n_cmp++; if (to || {rz, rx, ry} !== {16'd35, 16'd5, 16'd7}) begin n_fail++; $display("FAIL stall_result got z=%0d x=%0d y=%0d to=%b want 35 5 7 0", rz, rx, ry, to); end
        n_cmp++; if (rc !== 8'd4) begin n_fail++; $display("FAIL stall_count got %0d want 4", rc); end
    endtask

    task automatic test_backpressure;
        logic [15:0] rz, rx, ry, gx, gy;
        logic rv;
        logic [7:0] rc;
        bit ok, to, ack_seen, moved;
        res_ready = 1'b0;
        push_op(16'd2, 16'd3, LIMIT, ok);
        push_op(16'd4, 16'd5, LIMIT, ok);
        mul_op(rz, rx, ry, rv, rc, to);
        n_cmp++; if (to || {rv, rz, rc} !== {1'b1, 16'd6, 8'd5}) begin n_fail++; $display("FAIL bp_first got v=%b z=%0d cnt=%0d to=%b want 1 6 5 0", rv, rz, rc, to); end
        pull_xy(gx, gy, to);
        n_cmp++; if (to || {gx, gy} !== {16'd4, 16'd5}) begin n_fail++; $display("FAIL bp_pull got x=%0d y=%0d to=%b want 4 5 0", gx, gy, to); end
        z_0d = 16'd20;
        z_0r = 1'b1;
        ack_seen = 1'b0;
        moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (z_0a !== 1'b0) ack_seen = 1'b1;
            if (res_valid !== 1'b1 || res_z !== 16'd6 || res_x !== 16'd2) moved = 1'b1;
        end
        n_cmp++; if (ack_seen) begin n_fail++; $display("FAIL bp_z_withheld got ack want none"); end
        n_cmp++; if (moved) begin n_fail++; $display("FAIL bp_hold got v=%b z=%0d want 1 6 stable", res_valid, res_z); end
        res_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({res_valid, z_0a} !== 2'b00) begin n_fail++; $display("FAIL bp_consume got v=%b ack=%b want 0 0", res_valid, z_0a); end
        @(negedge clk);
        n_cmp++; if ({z_0a, res_valid} !== 2'b11) begin n_fail++; $display("FAIL bp_capture got ack=%b v=%b want 1 1", z_0a, res_valid); end
        n_cmp++; if ({res_z, res_x, res_y, count} !== {16'd20, 16'd4, 16'd5, 8'd6}) begin n_fail++; $display("FAIL bp_second got z=%0d x=%0d y=%0d cnt=%0d want 20 4 5 6", res_z, res_x, res_y, count); end
        z_0r = 1'b0;
        wait_ack(2, 1'b0, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL bp_rtz got timeout want z_0a low"); end
    endtask

    task automatic test_fifo_full;
        logic [15:0] ex [5] = '{16'd2, 16'd12, 16'd30, 16'd56, 16'd90};
        logic [15:0] rz, rx, ry;
        logic rv;
        logic [7:0] rc;
        bit ok, to;
        for (int i = 0; i < D; i++) begin
            push_op(16'(2 * i + 1), 16'(2 * i + 2), LIMIT, ok);
            n_cmp++; if (!ok || op_ready !== (i < D - 1)) begin n_fail++; $display("FAIL full_push%0d got ok=%b ready=%b want 1 %b", i, ok, op_ready, (i < D - 1)); end
        end
        repeat (5) @(negedge clk);
        n_cmp++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_stays_low got %b want 0", op_ready); end
        fork
            push_op(16'd9, 16'd10, 300, ok);
            mul_op(rz, rx, ry, rv, rc, to);
        join
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL full_push5 got rejected want accepted after drain"); end
        n_cmp++; if (to || {rz, rx, ry} !== {ex[0], 16'd1, 16'd2}) begin n_fail++; $display("FAIL full_res0 got z=%0d x=%0d y=%0d want 2 1 2", rz, rx, ry); end
        for (int i = 1; i < 5; i++) begin
            mul_op(rz, rx, ry, rv, rc, to);
            n_cmp++; if (to || {rz, rx} !== {ex[i], 16'(2 * i + 1)}) begin n_fail++; $display("FAIL full_res%0d got z=%0d x=%0d want %0d %0d", i, rz, rx, ex[i], 2 * i + 1); end
        end
        n_cmp++; if (rc !== 8'd11) begin n_fail++; $display("FAIL full_count got %0d want 11", rc); end
    endtask

    task automatic test_reset_mid;
        bit ok, to, seen;
        push_op(16'd6, 16'd7, LIMIT, ok);
        push_op(16'd8, 16'd9, LIMIT, ok);
        @(negedge clk);
        x_0r = 1'b1;
        wait_ack(0, 1'b1, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL rmid_ack got timeout want x_0a high"); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if ({x_0a, y_0a, z_0a, activate_0r, op_ready, res_valid} !== 6'b0) begin n_fail++; $display("FAIL rmid_async got %b want 000000", {x_0a, y_0a, z_0a, activate_0r, op_ready, res_valid}); end
        n_cmp++; if ({count, x_0d} !== 24'd0) begin n_fail++; $display("FAIL rmid_state got cnt=%0d x_0d=%0d want 0 0", count, x_0d); end
        x_0r = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if ({activate_0r, op_ready, count} !== {1'b1, 1'b1, 8'd0}) begin n_fail++; $display("FAIL rmid_release got act=%b rdy=%b cnt=%0d want 1 1 0", activate_0r, op_ready, count); end
        x_0r = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (x_0a !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_fail++; $display("FAIL rmid_discard got x_0a=1 want 0 (pairs dropped)"); end
        x_0r = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_product();
        test_stall();
        test_backpressure();
        test_fifo_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mul16_host.md
# booth_mul16_host

Synchronous host for the Balsa 16-bit Booth multiplier. It sits between clocked logic and the multiplier's four-phase channels. It raises `activate`, answers the multiplier's `x`/`y` pull requests from an operand FIFO, and accepts the `z` push channel into a result register with valid/ready back-pressure. It is the clocked, synthesisable counterpart of the multiplier's environment and is the standard way clocked subsystems reach the async core.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops in each request synchroniser (`x_0r`, `y_0r`, `z_0r`, `activate_0a`); legal values ≥ 2.
- `OP_DEPTH`, default 4: operand FIFO depth; power of 2, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `op_valid`  in  1  operand pair offered.
- `op_ready`  out  1  FIFO not full.
- `op_x`  in  16  multiplicand.
- `op_y`  in  16  multiplier.
- `res_valid`  out  1  result held.
- `res_ready`  in  1  result consumed.
- `res_z`  out  16  product, low 16 bits.
- `res_x`  out  16  echoed operand.
- `res_y`  out  16  echoed operand.
- `activate_0r`  out  1  activation request.
- `activate_0a`  in  1  activation acknowledge.
- `x_0r`  in  1  pull request.
- `x_0a`  out  1  pull acknowledge.
- `x_0d`  out  16  pull data.
- `y_0r`  in  1  pull request.
- `y_0a`  out  1  pull acknowledge.
- `y_0d`  out  16  pull data.
- `z_0r`  in  1  push request.
- `z_0a`  out  1  push acknowledge.
- `z_0d`  in  16  push data.
- `count`  out  8  completed results, mod 256.

## Operation
- Reset: every output is 0, including `op_ready`. The FIFO is empty, the current-pair register is invalid and `count` is 0. The multiplier must be reset concurrently by the system.
- Activation: `activate_0r` rises on the first edge after `reset` deasserts and stays high. `activate_0a` is synchronised and ignored; it is exposed for debug only.
- Operand FIFO: pushes when `op_valid && op_ready`, where `op_ready = !full`. A pop in the same cycle does not raise `op_ready` that cycle.
- Current pair: loaded from the FIFO head when the register is invalid and the FIFO is non-empty. It becomes invalid once both the `x` and `y` channels have completed their up-phase for that pair.
- x channel FSM, with states IDLE, DRIVE, ACK, RTZ:
  - IDLE → DRIVE on synced `x_0r` high with a valid pair not yet served on x. `x_0d` is loaded with `pair.x`.
  - DRIVE → ACK on the next edge; `x_0a` goes to 1. Data is therefore stable one full cycle before the acknowledge (bundled data).
  - ACK → RTZ on synced `x_0r` low; `x_0a` goes to 0.
  - RTZ → IDLE on the next edge.
  - `x_0d` holds its value until the next DRIVE.
  - If the pair is unavailable, the FSM stays in IDLE with `x_0a` low. This is a stall, not an error.
- y channel: identical FSM, serving `pair.y`. The x and y channels run independently and in either order.
- z channel FSM, with states IDLE, CAPT, ACK:
  - IDLE → CAPT on synced `z_0r` high when the result slot is free (`!res_valid`, or `res_ready` in the same cycle).
  - In CAPT, `z_0d` is sampled into `res_z`, `res_x`/`res_y` are loaded from the echo copy of the served pair, `res_valid` goes to 1, `count` increments, and `z_0a` goes to 1.
  - CAPT → ACK → IDLE once synced `z_0r` is low; `z_0a` returns to 0 on that transition.
  - If the slot is not free, the FSM stays in IDLE: the acknowledge is withheld, which back-pressures the multiplier.
- Result register: `res_valid` clears on `res_valid && res_ready` unless a new capture occurs in the same cycle.
- Arithmetic: `res_z` is whatever the multiplier pushes, the low 16 bits of the unsigned product. There is no overflow flag. `count` wraps 255 → 0.
- Reset mid-handshake: all acknowledges drop to 0 immediately (asynchronous) and any partially served pair is discarded.

## Timing
- Request-to-data latency: `SYNC_STAGES` edges from the request edge. Request-to-acknowledge latency: `SYNC_STAGES` + 1 edges.
- Return-to-zero: the acknowledge falls `SYNC_STAGES` + 1 edges after the request falls.
- z capture: `res_valid` and `z_0a` rise on the same edge, `SYNC_STAGES` + 1 edges after `z_0r` rises, provided the slot is free.
- Best-case throughput per operation is bounded by four synchronised handshake phases on each channel.
- `z_0d` must be stable from `z_0r` rise until `z_0a` rise. Sampling after synchronisation relies on this.

## Test plan
- Push (10000, 3) then (3, 10000) with `res_ready` held at 1, using a behavioural multiplier → two results, each `res_z` = 30000, echoes correct, `count` = 2.
- Push (0xFFFF, 0xFFFF) → `res_z` = 0x0001.
- Empty FIFO while `x_0r` is high for 20 cycles → `x_0a` stays 0. Push (5, 7) → `x_0a` rises `SYNC_STAGES` + 1 cycles later and `res_z` = 35.
- `res_ready` = 0 with two operations queued → first result held stable, second `z_0a` withheld. Raising `res_ready` → second result captured on the following cycle.
- `OP_DEPTH` + 1 back-to-back pushes with the multiplier stalled → `op_ready` falls after `OP_DEPTH` accepts. No pair is lost and results return in order.
- Assert `reset` while `x_0a` = 1 → all outputs 0 immediately. After release, `activate_0r` = 1 on the first edge and `count` = 0.
